// File: rtl/hash_pkg.sv
// hash_pkg: types and constants shared by the hash-table request stream
// transmitter and the hash-table pipeline behind it.
//   op_e       : 2-bit opcode carried in the top two bits of each stream word
//   tx_state_e : packet framing state of the transmitter
//   KEEP_ALL   : byte qualifier driven on every beat
package hash_pkg;

  typedef enum logic [1:0] {
    NOP    = 2'b00,
    READ   = 2'b01,
    WRITE  = 2'b10,
    DELETE = 2'b11
  } op_e;

  // IDLE: no beat of the current packet loaded yet; OPEN: at least one loaded.
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_OPEN = 1'b1
  } tx_state_e;

  localparam logic [7:0] KEEP_ALL = 8'hFF;

  // Nops are acknowledged but never occupy a FIFO slot.
  function automatic logic is_nop(input logic [1:0] op);
    return op == NOP;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write din_i (ignored when full)
//   din_i      : write data
//   pop_i      : advance read pointer (ignored when empty)
//   dout_o     : head entry (first-word fall-through)
//   count_o    : current number of entries
//   full_o     : count_o == DEPTH
// DEPTH must be a power of two so the pointers wrap by overflow.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Storage needs no reset: only entries below cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/hash_op_stream_tx.sv
// hash_op_stream_tx: turns hash-table commands into the framed request stream.
//   clk, reset      : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_payload_i : command handshake
//   flush_i         : pulse; close the open packet as soon as possible
//   data_o          : {op, payload}
//   valid_o/last_o/keep_o : output beat, packet end, byte qualifier
//   ready_i         : downstream backpressure
// Optional HASH_TX_STATS_EN adds stat_cmd_o / stat_nop_o / stat_pkt_o
// (16-bit wrapping: accepted non-nop commands, dropped nops, sent packets).
//
// A packet is only left open while another entry remains buffered, so the
// final beat of every packet can always be marked last at load time.
module hash_op_stream_tx
  import hash_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [DATA_WIDTH-3:0] cmd_payload_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [7:0]            keep_o,
  input  logic                  ready_i
`ifdef HASH_TX_STATS_EN
  ,
  output logic [15:0]           stat_cmd_o,
  output logic [15:0]           stat_nop_o,
  output logic [15:0]           stat_pkt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_dout;

  logic                  push, load, load_last, org_free, burst_end, n_one, n_ge2;
  logic                  cmd_fire;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, last_q;
  tx_state_e             state_q;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  flush_pend_q, flush_pend_d;

  assign cmd_ready_o = !fifo_full;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign push        = cmd_fire && !is_nop(cmd_op_i);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({cmd_op_i, cmd_payload_i}),
    .pop_i   (load),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .full_o  (fifo_full)
  );

  // Load decisions use the occupancy before this cycle's push.
  assign org_free  = !valid_q || ready_i;
  assign burst_end = (beat_cnt_q == BW'(MAX_BURST - 1));
  assign n_one     = (fifo_cnt == CW'(1));
  assign n_ge2     = (fifo_cnt >= CW'(2));

  always_comb begin
    load         = 1'b0;
    load_last    = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    flush_pend_d = flush_pend_q;

    if (org_free) begin
      if (n_ge2) begin
        load      = 1'b1;
        load_last = burst_end;
      end else if (n_one && (flush_pend_q || burst_end ||
                             idle_cnt_q == IW'(IDLE_TIMEOUT))) begin
        // The lone remaining entry has to close the packet.
        load      = 1'b1;
        load_last = 1'b1;
      end
    end

    if (load) beat_cnt_d = load_last ? '0 : beat_cnt_q + BW'(1);

    if (push || load || !n_one)              idle_cnt_d = '0;
    else if (idle_cnt_q != IW'(IDLE_TIMEOUT)) idle_cnt_d = idle_cnt_q + IW'(1);

    // A flush with nothing buffered and no open packet has nothing to close.
    if (load && load_last)                                    flush_pend_d = 1'b0;
    else if (flush_i && (fifo_cnt != '0 || state_q == TX_OPEN)) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TX_IDLE;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      flush_pend_q <= flush_pend_d;
      if (load) begin
        data_q  <= fifo_dout;
        last_q  <= load_last;
        valid_q <= 1'b1;
        state_q <= load_last ? TX_IDLE : TX_OPEN;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign keep_o  = KEEP_ALL;

`ifdef HASH_TX_STATS_EN
  logic [15:0] stat_cmd_q, stat_nop_q, stat_pkt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cmd_q <= '0;
      stat_nop_q <= '0;
      stat_pkt_q <= '0;
    end else begin
      if (push)                          stat_cmd_q <= stat_cmd_q + 16'd1;
      if (cmd_fire && is_nop(cmd_op_i))  stat_nop_q <= stat_nop_q + 16'd1;
      if (valid_q && ready_i && last_q)  stat_pkt_q <= stat_pkt_q + 16'd1;
    end
  end

  assign stat_cmd_o = stat_cmd_q;
  assign stat_nop_o = stat_nop_q;
  assign stat_pkt_o = stat_pkt_q;
`endif

endmodule

// File: tb/tb_hash_op_stream_tx.sv
// Directed bench for hash_op_stream_tx with a scoreboard of expected beats.
// Build with HASH_TX_STATS_EN defined to also check the statistics outputs.
module tb_hash_op_stream_tx;
  import hash_pkg::*;

  localparam int DW = 32;
  localparam int IT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid_i, cmd_ready_o, flush_i;
  logic [1:0]    cmd_op_i;
  logic [DW-3:0] cmd_payload_i;
  logic [DW-1:0] data_o;
  logic          valid_o, last_o, ready_i;
  logic [7:0]    keep_o;
`ifdef HASH_TX_STATS_EN
  logic [15:0]   stat_cmd_o, stat_nop_o, stat_pkt_o;
`endif

  always #5 clk = ~clk;

  hash_op_stream_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .MAX_BURST(4), .IDLE_TIMEOUT(IT)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_payload_i (cmd_payload_i),
    .flush_i       (flush_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .last_o        (last_o),
    .keep_o        (keep_o),
    .ready_i       (ready_i)
`ifdef HASH_TX_STATS_EN
    ,
    .stat_cmd_o    (stat_cmd_o),
    .stat_nop_o    (stat_nop_o),
    .stat_pkt_o    (stat_pkt_o)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   exp_cmd = 0, exp_nop = 0, exp_pkt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sample mid-cycle, a transfer happens at the next edge.
  exp_t e;
  always @(negedge clk) begin
    if (!reset && valid_o && ready_i) begin
      if (sb.size() == 0) chk("unexpected_beat", 64'(valid_o), 64'd0);
      else begin
        e = sb.pop_front();
        chk("beat_data", 64'(data_o), 64'(e.data));
        chk("beat_last", 64'(last_o), 64'(e.last));
        chk("beat_keep", 64'(keep_o), 64'hFF);
        if (e.last) exp_pkt++;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [DW-3:0] pl,
                      input logic lst, input logic fl);
    int t = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_payload_i = pl; flush_i = fl;
    while (!cmd_ready_o && t < 200) begin @(posedge clk); #1; t++; end
    chk("send_timeout", 64'(t < 200), 64'd1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; flush_i = 1'b0;
    if (op != NOP) begin sb.push_back({op, pl, lst}); exp_cmd++; end
    else exp_nop++;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1; @(posedge clk); #1; flush_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || valid_o) && t < 300) begin @(posedge clk); #1; t++; end
    chk("drain_timeout", 64'(t < 300), 64'd1);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!valid_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
  endtask

  logic [DW-1:0] d0;
  logic          l0;
  int            lat;

  initial begin
    reset = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'b00; cmd_payload_i = '0;
    flush_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_keep", 64'(keep_o), 64'hFF);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);

    // Lone WRITE goes out after the idle timeout as a single-beat packet.
    send(WRITE, 30'h123, 1'b1, 1'b0);
    wait_valid(lat);
    chk("lone_latency", 64'(lat), 64'(IT + 1));
    chk("lone_data", 64'(data_o), 64'h80000123);
    drain();

    // Flush with nothing buffered must not shorten the next lone command.
    pulse_flush();
    send(READ, 30'h55, 1'b1, 1'b0);
    wait_valid(lat);
    chk("ignored_flush_latency", 64'(lat), 64'(IT + 1));
    drain();

    // Three READs, flush with the third.
    send(READ, 30'h1, 1'b0, 1'b0);
    send(READ, 30'h2, 1'b0, 1'b0);
    send(READ, 30'h3, 1'b1, 1'b1);
    drain();

    // Ten DELETEs with MAX_BURST=4: last on beats 4, 8, 10.
    for (int i = 0; i < 10; i++)
      send(DELETE, 30'(32'h100 + i), (i == 3 || i == 7 || i == 9), 1'b0);
    pulse_flush();
    drain();

    // Backpressure: head beat held stable, FIFO fills, then ordered drain.
    ready_i = 1'b0;
    send(WRITE, 30'hA, 1'b0, 1'b0);
    send(WRITE, 30'hB, 1'b0, 1'b0);
    send(WRITE, 30'hC, 1'b0, 1'b0);
    send(WRITE, 30'hD, 1'b1, 1'b0);
    send(WRITE, 30'hE, 1'b1, 1'b0);
    chk("full_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("stall_valid", 64'(valid_o), 64'd1);
    d0 = data_o; l0 = last_o;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("stall_data", 64'(data_o), 64'(d0));
      chk("stall_last", 64'(last_o), 64'(l0));
    end
    chk("stall_head", 64'(d0), 64'h8000000A);
    ready_i = 1'b1;
    drain();

    // NOPs interleaved with READs: only READ beats appear.
    send(NOP,  30'h3FF, 1'b0, 1'b0);
    send(READ, 30'h21,  1'b0, 1'b0);
    send(NOP,  30'h3FE, 1'b0, 1'b0);
    send(READ, 30'h22,  1'b0, 1'b0);
    send(NOP,  30'h3FD, 1'b0, 1'b0);
    send(READ, 30'h23,  1'b1, 1'b1);
    drain();
`ifdef HASH_TX_STATS_EN
    chk("stat_cmd", 64'(stat_cmd_o), 64'(exp_cmd));
    chk("stat_nop", 64'(stat_nop_o), 64'(exp_nop));
    chk("stat_pkt", 64'(stat_pkt_o), 64'(exp_pkt));
`endif

    // Reset while beat 2 of a packet is stalled.
    ready_i = 1'b0;
    send(READ, 30'h31, 1'b0, 1'b0);
    send(READ, 30'h32, 1'b0, 1'b0);
    send(READ, 30'h33, 1'b0, 1'b0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("beat2_valid", 64'(valid_o), 64'd1);
    chk("beat2_data", 64'(data_o), 64'h40000032);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_fifo", 64'(dut.fifo_cnt), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
`ifdef HASH_TX_STATS_EN
    chk("mid_rst_stat_cmd", 64'(stat_cmd_o), 64'd0);
`endif
    // New packet starts with beat count 0: last only on the fourth beat.
    ready_i = 1'b1;
    send(READ, 30'h41, 1'b0, 1'b0);
    send(READ, 30'h42, 1'b0, 1'b0);
    send(READ, 30'h43, 1'b0, 1'b0);
    send(READ, 30'h44, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
